psg_bus_writer: RTL and testbench
=================================

PSG_BUS_WRITER -- requirements
Module: psg_bus_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, request buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter IDLE_REG, default 4'hF, register index addressed during idle slots (unused by PSG).
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high; clock clk.
REQ-005 SHALL have port req_valid  input  1  write request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-007 SHALL have port req_addr  input  4  target PSG register R0..R15.
REQ-008 SHALL have port req_data  input  8  value to write.
REQ-009 SHALL have port bus_out  output  8  byte driven onto PSG ui_in.
REQ-010 SHALL have port wr_done  output  1  one-cycle pulse while a request's data byte is on bus_out.
REQ-011 SHALL have port busy  output  1  FIFO non-empty or transaction in flight.
REQ-012 SHALL have port shadow_addr  input  4  shadow readback index.
REQ-013 SHALL have port shadow_data  output  8  shadow readback value.

Function
REQ-014 SHALL keep phase bit ph, 0 after reset, toggling every cycle; ph=0 cycle = data slot, ph=1 cycle = address slot (matches PSG, whose latch is 0 after the shared reset).
REQ-015 SHALL register bus_out; all bus_out changes occur on clk edges only.
REQ-016 At the edge ending a data slot: if FIFO non-empty, SHALL pop head into cur {addr,data}, set cur_valid, load bus_out={4'h0,addr}; else clear cur_valid, load bus_out={4'h0,IDLE_REG}.
REQ-017 At the edge ending an address slot: SHALL load bus_out=cur_data if cur_valid, else 8'h00.
REQ-018 wr_done SHALL be high exactly in data slots carrying cur_data with cur_valid=1.
REQ-019 req_ready SHALL equal !full; push occurs on req_valid && req_ready at a clk edge.
REQ-020 No FIFO bypass: a request pushed at an edge SHALL NOT be popped at that same edge; data byte appears 3 cycles (accepted in ph=1) or 4 cycles (accepted in ph=0) after the acceptance cycle, empty FIFO.
REQ-021 Simultaneous push and pop SHALL both take effect; count unchanged.
REQ-022 Full FIFO SHALL hold req_ready low; no entry overwritten; order strictly FIFO.
REQ-023 Sustained throughput SHALL be one write per 2 cycles.
REQ-024 busy SHALL equal (count!=0) | cur_valid.
REQ-025 All 16 addresses SHALL be forwarded unmodified, including IDLE_REG.

Reset
REQ-026 Reset SHALL set ph=0, bus_out=8'h00, cur_valid=0, FIFO empty, wr_done=0, busy=0, req_ready=1, shadow all 0.
REQ-027 Reset mid-transaction SHALL discard FIFO and in-flight write; PSG and writer SHALL share the same reset so phases stay aligned.

Configuration
REQ-028 With PSG_SHADOW_EN defined: 16x8 shadow array SHALL be written with cur_data at cur_addr in every wr_done cycle and with 8'h00 at IDLE_REG in every idle data slot; shadow_data = shadow[shadow_addr] combinationally.
REQ-029 Without PSG_SHADOW_EN: no shadow storage; shadow_data SHALL be tied 8'h00.

Structure
REQ-030 Shared package psg_pkg SHALL hold register-index constants R_TONE_A_FINE..R_ENV_SHAPE, IDLE_REG default, and the write request typedef {addr[3:0],data[7:0]}.
REQ-031 FIFO SHALL be sub-module psg_wr_fifo (push/pop/full/empty/count, synchronous reset).

Verification
REQ-032 Single write: reset, then req {R8,8'h1F} accepted in ph=1 cycle -> bus_out 8'h08 two cycles later, 8'h1F next cycle with wr_done=1; PSG model R8=8'h1F.
REQ-033 Idle: no requests for 20 cycles after reset -> bus_out alternates 8'h00 (data) / 8'h0F (address); PSG model R0..R14 stay 0.
REQ-034 Burst: 6 back-to-back reqs R0..R5 = 8'hA0..8'hA5, FIFO_DEPTH=4 -> req_ready drops when full, all 6 written in order, one per 2 cycles, 6 wr_done pulses.
REQ-035 Reset mid-burst: assert reset with 3 entries queued -> bus_out 8'h00, busy=0 next cycle; no queued write reaches PSG model.
REQ-036 Shadow (PSG_SHADOW_EN): write R12=8'h5A -> shadow_addr=12 reads 8'h5A from the wr_done cycle's next edge; without macro reads 8'h00.
REQ-037 Scoreboard: 1000 random reqs with random req_valid gaps -> PSG model register file equals expected after busy falls.

Source files
------------

// File: rtl/psg_pkg.sv
// Shared definitions for the PSG register-write path: register indices,
// the write request layout and the bus phase encoding.
package psg_pkg;

   localparam logic [3:0] R_TONE_A_FINE    = 4'd0;
   localparam logic [3:0] R_TONE_A_COARSE  = 4'd1;
   localparam logic [3:0] R_TONE_B_FINE    = 4'd2;
   localparam logic [3:0] R_TONE_B_COARSE  = 4'd3;
   localparam logic [3:0] R_TONE_C_FINE    = 4'd4;
   localparam logic [3:0] R_TONE_C_COARSE  = 4'd5;
   localparam logic [3:0] R_NOISE_PERIOD   = 4'd6;
   localparam logic [3:0] R_MIXER          = 4'd7;
   localparam logic [3:0] R_AMP_A          = 4'd8;
   localparam logic [3:0] R_AMP_B          = 4'd9;
   localparam logic [3:0] R_AMP_C          = 4'd10;
   localparam logic [3:0] R_ENV_FINE       = 4'd11;
   localparam logic [3:0] R_ENV_COARSE     = 4'd12;
   localparam logic [3:0] R_ENV_SHAPE      = 4'd13;

   // R15 is not decoded by the PSG, so idle slots park the address latch there.
   localparam logic [3:0] IDLE_REG_DEFAULT = 4'hF;

   typedef struct packed {
      logic [3:0] addr;
      logic [7:0] data;
   } psg_req_t;

   localparam int REQ_W = $bits(psg_req_t);

   typedef enum logic {
      PH_DATA = 1'b0,
      PH_ADDR = 1'b1
   } psg_phase_t;

endpackage

// File: rtl/psg_wr_fifo.sv
// Request buffer for the PSG bus writer: DEPTH-entry FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap without extra logic.
module psg_wr_fifo
   import psg_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [REQ_W-1:0]       wr_data,
   input  logic                   pop,
   output logic [REQ_W-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [REQ_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // sees the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; validity is defined solely by the
   // pointers and count, which keeps the array a plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/psg_bus_writer.sv
// Serialises PSG register writes onto the shared 8-bit bus as alternating
// address/data slots. Optional shadow register file enabled by PSG_SHADOW_EN.
module psg_bus_writer
   import psg_pkg::*;
#(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [3:0] IDLE_REG   = IDLE_REG_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_addr,
   input  logic [7:0] req_data,
   output logic [7:0] bus_out,
   output logic       wr_done,
   output logic       busy,
   input  logic [3:0] shadow_addr,
   output logic [7:0] shadow_data
);

   psg_phase_t                   ph;
   psg_req_t                     cur;
   logic                         cur_valid;
   psg_req_t                     fifo_head;
   logic                         fifo_full;
   logic                         fifo_empty;
   logic                         fifo_pop;
   logic [$clog2(FIFO_DEPTH):0]  fifo_count;

   // Popping only at the end of a data slot gives the no-bypass behaviour:
   // an entry pushed at this edge is not yet visible as the head.
   assign fifo_pop  = (ph == PH_DATA) && !fifo_empty;
   assign req_ready = !fifo_full;
   assign busy      = (fifo_count != '0) || cur_valid;

   psg_wr_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (req_valid),
      .wr_data ({req_addr, req_data}),
      .pop     (fifo_pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         ph        <= PH_DATA;
         bus_out   <= 8'h00;
         cur       <= '0;
         cur_valid <= 1'b0;
         wr_done   <= 1'b0;
      end else begin
         ph <= (ph == PH_DATA) ? PH_ADDR : PH_DATA;
         if (ph == PH_DATA) begin
            wr_done <= 1'b0;
            if (!fifo_empty) begin
               cur       <= fifo_head;
               cur_valid <= 1'b1;
               bus_out   <= {4'h0, fifo_head.addr};
            end else begin
               cur_valid <= 1'b0;
               bus_out   <= {4'h0, IDLE_REG};
            end
         end else begin
            bus_out <= cur_valid ? cur.data : 8'h00;
            wr_done <= cur_valid;
         end
      end
   end

`ifdef PSG_SHADOW_EN
   logic [7:0] shadow [16];

   // Mirrors exactly what the PSG latches, including the zero written to
   // IDLE_REG by every idle data slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) shadow[i] <= 8'h00;
      end else if (ph == PH_DATA) begin
         if (cur_valid) shadow[cur.addr] <= cur.data;
         else           shadow[IDLE_REG] <= 8'h00;
      end
   end

   assign shadow_data = shadow[shadow_addr];
`else
   logic unused_shadow_addr;
   assign unused_shadow_addr = ^shadow_addr;
   assign shadow_data        = 8'h00;
`endif

endmodule

// File: tb/tb_psg_bus_writer.sv
// Self-checking bench for psg_bus_writer: PSG receiver model plus a
// request scoreboard; shadow expectations follow PSG_SHADOW_EN.
module tb_psg_bus_writer;
   import psg_pkg::*;

`ifdef PSG_SHADOW_EN
   localparam logic [7:0] SHADOW_EXP = 8'h5A;
`else
   localparam logic [7:0] SHADOW_EXP = 8'h00;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic [3:0] req_addr = 4'h0;
   logic [7:0] req_data = 8'h00;
   logic [3:0] shadow_addr = 4'h0;
   logic       req_ready;
   logic [7:0] bus_out;
   logic       wr_done;
   logic       busy;
   logic [7:0] shadow_data;

   int n_tests = 0;
   int n_fail  = 0;

   // PSG receiver model and expected register file
   logic       m_ph;
   logic [3:0] m_addr;
   logic [7:0] m_regs [16];
   logic [7:0] exp_regs [16];
   psg_req_t   exp_q [$];

   psg_bus_writer #(
      .FIFO_DEPTH (4),
      .IDLE_REG   (4'hF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .bus_out     (bus_out),
      .wr_done     (wr_done),
      .busy        (busy),
      .shadow_addr (shadow_addr),
      .shadow_data (shadow_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_phase(input logic p);
      if (m_ph !== p) step();
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int i = 0;
      while (busy && i < budget) begin
         @(negedge clk);
         i++;
      end
      check(tag, busy, 0);
   endtask

   task automatic count_nonzero(output int nz);
      nz = 0;
      for (int i = 0; i < 15; i++) if (m_regs[i] != 8'h00) nz++;
   endtask

   // PSG: latch address in address slots, write register in data slots
   always @(posedge clk) begin
      if (reset) begin
         m_ph   <= 1'b0;
         m_addr <= 4'hF;
         for (int i = 0; i < 16; i++) m_regs[i] <= 8'h00;
      end else begin
         m_ph <= ~m_ph;
         if (m_ph) m_addr <= bus_out[3:0];
         else      m_regs[m_addr] <= bus_out;
      end
   end

   // Scoreboard: push on acceptance, pop and compare on each wr_done
   always @(negedge clk) begin
      psg_req_t e;
      if (wr_done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("wr_unexpected", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("wr_data", bus_out, e.data);
            check("wr_addr", m_addr, e.addr);
            check("wr_slot", m_ph, 0);
         end
      end
      if (reset) begin
         exp_q.delete();
         for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
      end else if (req_valid && req_ready) begin
         exp_q.push_back(psg_req_t'{addr: req_addr, data: req_data});
         exp_regs[req_addr] = req_data;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int nz;
      int nwr;
      int last_cyc;
      int bad_gap;
      logic saw_full;
      logic acc;
      logic got;
      int n;
      int guard;

      // Reset state
      reset = 1'b1;
      repeat (3) step();
      @(negedge clk);
      check("rst_bus_out", bus_out, 8'h00);
      check("rst_wr_done", wr_done, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", req_ready, 1);
      check("rst_shadow", shadow_data, 8'h00);
      step();
      reset = 1'b0;

      // Idle: data slots 00, address slots 0F
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check($sformatf("idle_bus_%0d", i), bus_out, (i % 2) ? 8'h0F : 8'h00);
      end
      count_nonzero(nz);
      check("idle_regs_nonzero", nz, 0);
      step();

      // Single write accepted in an address-slot cycle
      wait_phase(1'b1);
      req_valid = 1'b1;
      req_addr  = R_AMP_A;
      req_data  = 8'h1F;
      @(negedge clk);
      check("single_accept", req_ready, 1);
      step();
      req_valid = 1'b0;
      step();
      @(negedge clk);
      check("single_addr_byte", bus_out, 8'h08);
      check("single_addr_wr_done", wr_done, 0);
      @(negedge clk);
      check("single_data_byte", bus_out, 8'h1F);
      check("single_data_wr_done", wr_done, 1);
      step();
      @(negedge clk);
      check("single_psg_r8", m_regs[8], 8'h1F);
      wait_idle(20, "single_idle");

      // Burst of 6 into a 4-deep FIFO, starting in a data slot
      step();
      wait_phase(1'b0);
      nwr = 0; last_cyc = 0; bad_gap = 0; saw_full = 1'b0; n = 0;
      req_valid = 1'b1;
      req_addr  = 4'd0;
      req_data  = 8'hA0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (!req_ready) saw_full = 1'b1;
         if (wr_done) begin
            if (nwr > 0 && cyc - last_cyc != 2) bad_gap++;
            last_cyc = cyc;
            nwr++;
         end
         acc = req_valid && req_ready;
         step();
         if (acc) begin
            n++;
            if (n < 6) begin
               req_addr = 4'(n);
               req_data = 8'hA0 + 8'(n);
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      check("burst_accepted", n, 6);
      check("burst_wr_cnt", nwr, 6);
      check("burst_full_seen", saw_full, 1);
      check("burst_gap", bad_gap, 0);
      check("burst_q_empty", exp_q.size(), 0);
      for (int i = 0; i < 6; i++)
         check($sformatf("burst_R%0d", i), m_regs[i], 8'hA0 + 8'(i));

      // Shadow readback of R12
      shadow_addr = R_ENV_COARSE;
      req_valid   = 1'b1;
      req_addr    = R_ENV_COARSE;
      req_data    = 8'h5A;
      @(negedge clk);
      check("shadow_accept", req_ready, 1);
      step();
      req_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (wr_done) got = 1'b1;
      end
      check("shadow_wr_seen", got, 1);
      step();
      @(negedge clk);
      check("shadow_r12", shadow_data, SHADOW_EXP);
      wait_idle(20, "shadow_idle");

      // Reset with requests queued and one in flight
      step();
      wait_phase(1'b0);
      for (int k = 0; k < 3; k++) begin
         req_valid = 1'b1;
         req_addr  = 4'(k + 1);
         req_data  = 8'hC0 + 8'(k);
         step();
      end
      req_valid = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      check("midrst_busy_pre", busy, 1);
      step();
      @(negedge clk);
      check("midrst_bus_out", bus_out, 8'h00);
      check("midrst_busy", busy, 0);
      check("midrst_wr_done", wr_done, 0);
      check("midrst_req_ready", req_ready, 1);
      check("midrst_q_empty", exp_q.size(), 0);
      step();
      reset = 1'b0;
      repeat (12) step();
      count_nonzero(nz);
      check("midrst_regs_nonzero", nz, 0);

      // Random requests with random gaps
      n = 0;
      guard = 0;
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = 4'($urandom_range(0, 15));
      req_data  = 8'($urandom_range(0, 255));
      while (n < 1000 && guard < 20000) begin
         @(negedge clk);
         acc = req_valid && req_ready;
         if (acc) n++;
         step();
         guard++;
         if (acc || !req_valid) begin
            req_valid = ($urandom_range(0, 3) != 0) && (n < 1000);
            req_addr  = 4'($urandom_range(0, 15));
            req_data  = 8'($urandom_range(0, 255));
         end
      end
      req_valid = 1'b0;
      check("rand_accepted", n, 1000);
      wait_idle(100, "rand_idle");
      step();
      @(negedge clk);
      for (int i = 0; i < 15; i++)
         check($sformatf("rand_R%0d", i), m_regs[i], exp_regs[i]);
      check("rand_q_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
